// File: rtl/divmmc_mapper.sv
// DivMMC paging controller: port 0xE3 register, automap state machine and the
// 0x0000-0x3FFF chip-select decode feeding the ROM/RAM select logic.
module divmmc_mapper #(
  parameter int BANK_BITS    = 4,
  parameter bit ENTRY_NMI_EN = 1'b1,
  parameter bit ROM3_ONLY    = 1'b0
) (
  input  logic                 clk28,
  input  logic                 rst,
  input  logic                 en,
  input  logic [15:0]          a,
  input  logic [7:0]           d,
  input  logic                 n_m1,
  input  logic                 n_mreq,
  input  logic                 n_iorq,
  input  logic                 n_rd,
  input  logic                 n_wr,
  input  logic                 n_rfsh,
  input  logic                 rom_page3,
  input  logic                 dffd_cpm,
  output logic                 n_romcs0,
  output logic                 n_ramcs,
  output logic                 div_rom,
  output logic                 div_ram,
  output logic [BANK_BITS-1:0] div_bank,
  output logic                 ram_wp,
  output logic                 conmem,
  output logic                 mapram,
  output logic                 automap
);

  logic                 conmem_q, conmem_d;
  logic                 mapram_q, mapram_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 automap_q, automap_d;
  logic                 pending_q, pending_d;
  logic                 io_wr_q, io_wr_d;
  logic                 fetch_q, fetch_d;
  logic                 n_m1_q, n_m1_d;

  logic io_wr, fetch, entry_addr, entry_hit, off_hit, instant_hit;
  logic mem, lo, automap_eff, map;

  always_comb begin
    // n_rd high keeps a corrupted bus cycle from being taken as an E3 write
    io_wr       = !n_iorq && !n_wr && n_rd && n_m1 && (a[7:0] == 8'hE3);
    fetch       = !n_m1 && !n_mreq && n_rfsh;
    entry_addr  = (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
                  (ENTRY_NMI_EN && (a == 16'h0066)) ||
                  (a == 16'h04C6) || (a == 16'h0562);
    entry_hit   = entry_addr && (!ROM3_ONLY || rom_page3);
    off_hit     = (a[15:3] == 13'h03FF);
    instant_hit = en && fetch && (a[15:8] == 8'h3D) && rom_page3;
  end

  always_comb begin
    conmem_d  = conmem_q;
    mapram_d  = mapram_q;
    bank_d    = bank_q;
    automap_d = automap_q;
    pending_d = pending_q;
    io_wr_d   = io_wr;
    fetch_d   = fetch;
    n_m1_d    = n_m1;
    if (io_wr && !io_wr_q) begin
      conmem_d = d[7];
      mapram_d = mapram_q | d[6];
      bank_d   = BANK_BITS'(d);
    end
    if (fetch && !fetch_q) begin
      if (entry_hit) begin
        pending_d = 1'b1;
      end else if (off_hit) begin
        pending_d = 1'b0;
      end else if (instant_hit) begin
        automap_d = 1'b1;
        pending_d = 1'b1;
      end
    end
    // End of the M1 cycle: entry/exit decisions take effect for the next fetch
    if (n_m1 && !n_m1_q) begin
      automap_d = pending_q;
    end
    if (!en) begin
      automap_d = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      conmem_q  <= 1'b0;
      mapram_q  <= 1'b0;
      bank_q    <= '0;
      automap_q <= 1'b0;
      pending_q <= 1'b0;
      io_wr_q   <= 1'b0;
      fetch_q   <= 1'b0;
      n_m1_q    <= 1'b1;
    end else begin
      conmem_q  <= conmem_d;
      mapram_q  <= mapram_d;
      bank_q    <= bank_d;
      automap_q <= automap_d;
      pending_q <= pending_d;
      io_wr_q   <= io_wr_d;
      fetch_q   <= fetch_d;
      n_m1_q    <= n_m1_d;
    end
  end

  // Instant entry maps the very opcode read that triggered it
  always_comb begin
    mem         = !n_mreq && n_rfsh;
    lo          = (a[15:14] == 2'b00);
    automap_eff = automap_q || instant_hit;
    map         = conmem_q || automap_eff;
    div_ram     = mem && lo && ((map && a[13]) ||
                  (!conmem_q && automap_eff && mapram_q && !a[13]));
    div_rom     = mem && lo && !a[13] && map && !div_ram;
    n_ramcs     = !(mem && (!lo || div_ram || (dffd_cpm && !map)));
    n_romcs0    = !(mem && lo && !div_ram && !div_rom && !(dffd_cpm && !map));
    div_bank    = '0;
    if (div_ram) begin
      div_bank = a[13] ? bank_q : BANK_BITS'(3);
    end
    ram_wp      = div_ram && (!a[13] ||
                  (!conmem_q && mapram_q && (bank_q == BANK_BITS'(3))));
    conmem      = conmem_q;
    mapram      = mapram_q;
    automap     = automap_q;
  end

endmodule

// File: tb/tb_divmmc_mapper.sv
// Scoreboard bench for divmmc_mapper: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_divmmc_mapper;

  logic        clk28 = 1'b0;
  logic        rst, en, n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, rom_page3, dffd_cpm;
  logic [15:0] a;
  logic [7:0]  d;
  logic        n_romcs0, n_ramcs, div_rom, div_ram, ram_wp, conmem, mapram, automap;
  logic [3:0]  div_bank;

  typedef struct {
    string       name;
    logic [11:0] exp;
    bit          mem;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk28 = ~clk28;

  divmmc_mapper #(.BANK_BITS(4), .ENTRY_NMI_EN(1'b1), .ROM3_ONLY(1'b0)) dut (
    .clk28(clk28), .rst(rst), .en(en), .a(a), .d(d),
    .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
    .n_rfsh(n_rfsh), .rom_page3(rom_page3), .dffd_cpm(dffd_cpm),
    .n_romcs0(n_romcs0), .n_ramcs(n_ramcs), .div_rom(div_rom), .div_ram(div_ram),
    .div_bank(div_bank), .ram_wp(ram_wp), .conmem(conmem), .mapram(mapram),
    .automap(automap)
  );

  // {n_romcs0, n_ramcs, div_rom, div_ram, ram_wp, conmem, mapram, automap, div_bank}
  function automatic logic [11:0] mk(input logic nrom, nram, drom, dram, wp, cm, mr, am,
                                     input logic [3:0] bk);
    return {nrom, nram, drom, dram, wp, cm, mr, am, bk};
  endfunction

  // Reference decode written as a priority list of access targets
  function automatic logic [11:0] gold(input logic [2:0] hi, input logic cm, mr, am, dffd,
                                       input logic [3:0] bk);
    logic nrom, nram, drom, dram, wp, map;
    logic [3:0] db;
    nrom = 1; nram = 1; drom = 0; dram = 0; wp = 0; db = 0;
    map = cm | am;
    if (hi[2:1] != 2'b00) nram = 0;
    else if (hi[0] && map) begin
      dram = 1; nram = 0; db = bk; wp = !cm && mr && (bk == 4'd3);
    end else if (!hi[0] && !cm && am && mr) begin
      dram = 1; nram = 0; db = 4'd3; wp = 1;
    end else if (!hi[0] && map) drom = 1;
    else if (dffd && !map) nram = 0;
    else nrom = 0;
    return {nrom, nram, drom, dram, wp, cm, mr, am, db};
  endfunction

  always @(negedge clk28) begin
    exp_t        e;
    logic [11:0] act;
    logic [2:0]  oh;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {n_romcs0, n_ramcs, div_rom, div_ram, ram_wp, conmem, mapram, automap, div_bank};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, act, e.exp);
      end
      if (e.mem) begin
        oh = {!n_romcs0, !n_ramcs, div_rom};
        checks++;
        if (!$onehot(oh)) begin
          errors++;
          $display("FAIL %s_onehot: got %b want exactly one select", e.name, oh);
        end
      end
    end
  end

  task automatic push(input string name, input logic [11:0] exp, input bit mem);
    exp_t e;
    e.name = name; e.exp = exp; e.mem = mem;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic idle();
    n_m1 = 1; n_mreq = 1; n_iorq = 1; n_rd = 1; n_wr = 1; n_rfsh = 1;
    a = 16'h0000; d = 8'h00;
  endtask

  // Strobe held two clocks; the second data value must be ignored
  task automatic io_write(input logic [7:0] v, input logic [7:0] v2);
    step(); idle(); a = 16'h00E3; d = v; n_iorq = 0; n_wr = 0;
    step(); d = v2;
    step(); idle();
  endtask

  task automatic read(input logic [15:0] addr);
    step(); idle(); a = addr; n_mreq = 0; n_rd = 0;
  endtask

  task automatic fetch_begin(input logic [15:0] addr);
    step(); idle(); a = addr; n_m1 = 0; n_mreq = 0; n_rd = 0;
  endtask

  task automatic fetch_end();
    step(); n_m1 = 1; n_rd = 1; n_mreq = 0; n_rfsh = 0; a = 16'h0000;
    step(); idle();
  endtask

  initial begin
    idle();
    rst = 1; en = 1; rom_page3 = 0; dffd_cpm = 0;
    step(); step();
    push("reset", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    rst = 0;

    io_write(8'hC5, 8'h02);
    read(16'h2000); push("e3_bank5", mk(1,0,0,1,0,1,1,0,4'h5), 1);
    read(16'h0000); push("conmem_rom", mk(1,1,1,0,0,1,1,0,4'h0), 1);
    read(16'h4000); push("upper_ram", mk(1,0,0,0,0,1,1,0,4'h0), 1);
    io_write(8'h00, 8'h00);
    read(16'h0000); push("sticky_mapram", mk(0,1,0,0,0,0,1,0,4'h0), 1);
    step(); idle(); rst = 1;
    step(); rst = 0;
    push("rst_clears_mapram", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    io_write(8'h9A, 8'h9A);
    read(16'h2000); push("bank_trunc", mk(1,0,0,1,0,1,0,0,4'hA), 1);
    io_write(8'h00, 8'h00);

    fetch_begin(16'h0038); push("entry_fetch_t1", mk(0,1,0,0,0,0,0,0,4'h0), 1);
    step();                push("entry_fetch_t2", mk(0,1,0,0,0,0,0,0,4'h0), 1);
    step(); n_m1 = 1; n_rd = 1; n_mreq = 0; n_rfsh = 0; a = 16'h0000;
    push("refresh_none", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    step(); idle();
    push("automap_set", mk(1,1,0,0,0,0,0,1,4'h0), 0);
    fetch_begin(16'h0100); push("next_fetch_rom", mk(1,1,1,0,0,0,0,1,4'h0), 1);
    fetch_end();
    read(16'h2000); push("automap_ram", mk(1,0,0,1,0,0,0,1,4'h0), 1);

    fetch_begin(16'h1FF9); push("off_fetch_mapped", mk(1,1,1,0,0,0,0,1,4'h0), 1);
    fetch_end();           push("off_unmapped", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    read(16'h0000);        push("off_rom", mk(0,1,0,0,0,0,0,0,4'h0), 1);

    rom_page3 = 1;
    fetch_begin(16'h3D00); push("instant_t1", mk(1,0,0,1,0,0,0,0,4'h0), 1);
    step();                push("instant_t2", mk(1,0,0,1,0,0,0,1,4'h0), 1);
    fetch_end();
    read(16'h0000);        push("instant_rom", mk(1,1,1,0,0,0,0,1,4'h0), 1);
    rom_page3 = 0;

    step(); idle(); en = 0;
    step();                push("en_clear", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    io_write(8'h83, 8'h83);
    read(16'h2000);        push("en0_e3", mk(1,0,0,1,0,1,0,0,4'h3), 1);
    io_write(8'h00, 8'h00);
    fetch_begin(16'h0000);
    fetch_end();           push("en0_entry", mk(1,1,0,0,0,0,0,0,4'h0), 0);
    en = 1;
    fetch_begin(16'h0100); push("en0_no_pending", mk(0,1,0,0,0,0,0,0,4'h0), 1);
    fetch_end();
    fetch_begin(16'h3D00); push("no_rom3", mk(0,1,0,0,0,0,0,0,4'h0), 1);
    fetch_end();           push("no_rom3_after", mk(1,1,0,0,0,0,0,0,4'h0), 0);

    for (int m = 0; m < 2; m++) begin
      step(); idle(); rst = 1;
      step(); rst = 0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [3:0] bk;
          bk = (b == 0) ? 4'd3 : 4'd6;
          io_write({c[0], m[0], 2'b00, bk}, {c[0], m[0], 2'b00, bk});
          for (int am = 0; am < 2; am++) begin
            step(); idle(); en = 0;
            step(); en = 1;
            if (am == 1) begin
              fetch_begin(16'h0000);
              fetch_end();
            end
            for (int df = 0; df < 2; df++) begin
              for (int hi = 0; hi < 8; hi++) begin
                read({hi[2:0], 13'h0123});
                dffd_cpm = df[0];
                push("sweep", gold(hi[2:0], c[0], m[0], am[0], df[0], bk), 1);
              end
            end
            step(); idle(); dffd_cpm = 0;
          end
        end
      end
    end

    repeat (2) @(posedge clk28);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk28);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
